// File: rtl/math_adder_pkg.sv
// Shared types and constants for the Brent-Kung adder sum pipeline.
// The result record is fixed at the default width; wider instances build the same layout locally.
package math_adder_pkg;

  localparam int SUM_N     = 8;
  localparam int BUF_DEPTH = 2;

  typedef struct packed {
    logic [SUM_N-1:0] sum;
    logic             cout;
    logic             ovf;
  } sum_rec_t;

  // Width of one packed result record for an n-bit adder.
  function automatic int rec_width(input int n);
    return n + 2;
  endfunction

endpackage

// File: rtl/math_adder_brent_kung_sum.sv
// Final XOR stage of a prefix adder: sum, carry-out and signed overflow.
// Latency: combinational, zero cycles.
// Backpressure: none, this slice has no handshake.
module math_adder_brent_kung_sum #(
  parameter int N = 8
) (
  input  logic [N:0]   gg,
  input  logic [N:0]   p,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  // p[0] has no meaning; the carry-in already lives in gg[0].
  logic unused_p0;
  assign unused_p0 = p[0];

  assign sum  = p[N:1] ^ gg[N-1:0];
  assign cout = gg[N];
  // Carry into the sign bit differs from carry out of it.
  assign ovf  = gg[N] ^ gg[N-1];

endmodule

// File: rtl/math_adder_brent_kung_sum_pipe.sv
// Sum stage of the Brent-Kung adder with a 2-entry elastic output buffer.
// Latency: 1 cycle from push into an empty buffer to o_valid; 1 result/cycle sustained.
// Backpressure: o_ready depends only on registered occupancy, no path from i_ready.
module math_adder_brent_kung_sum_pipe
  import math_adder_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N:0]   i_gg,
  input  logic [N:0]   i_p,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_sum,
  output logic         o_cout,
  output logic         o_ovf
);

  typedef struct packed {
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
  } entry_t;

  localparam logic [1:0] FULL_CNT = 2'(BUF_DEPTH);

  entry_t     mem [BUF_DEPTH];
  entry_t     new_entry;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;

  math_adder_brent_kung_sum #(
    .N (N)
  ) u_sum (
    .gg   (i_gg),
    .p    (i_p),
    .sum  (new_entry.sum),
    .cout (new_entry.cout),
    .ovf  (new_entry.ovf)
  );

  assign o_ready = (count != FULL_CNT);
  assign o_valid = (count != 2'd0);
  assign push    = i_valid && o_ready;
  assign pop     = o_valid && i_ready;

  // Storage is written only on push, so idle-cycle X on the inputs never lands.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign o_sum  = mem[rd_ptr].sum;
  assign o_cout = mem[rd_ptr].cout;
  assign o_ovf  = mem[rd_ptr].ovf;

endmodule

// File: tb/tb_math_adder_brent_kung_sum_pipe.sv
// Scoreboard bench for the Brent-Kung sum pipeline: directed vectors, backpressure, reset, random traffic.
module tb_math_adder_brent_kung_sum_pipe;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [N:0]   i_gg = '0;
  logic [N:0]   i_p = '0;
  logic         o_valid;
  logic         i_ready = 1'b0;
  logic [N-1:0] o_sum;
  logic         o_cout;
  logic         o_ovf;

  int checks = 0;
  int errors = 0;
  logic [N+1:0] exp_q[$];
  bit rnd_ready = 1'b0;

  always #5 clk = ~clk;

  math_adder_brent_kung_sum_pipe #(
    .N (N)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_gg    (i_gg),
    .i_p     (i_p),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_sum   (o_sum),
    .o_cout  (o_cout),
    .o_ovf   (o_ovf)
  );

  // Ripple prefix model: gg[k] is the carry into operand bit k.
  function automatic logic [N:0] prefix_gg(input logic [N-1:0] a, b, input logic cin);
    logic [N:0] gg;
    gg[0] = cin;
    for (int k = 1; k <= N; k++) begin
      gg[k] = (a[k-1] & b[k-1]) | ((a[k-1] ^ b[k-1]) & gg[k-1]);
    end
    return gg;
  endfunction

  // Arithmetic reference, independent of the prefix vectors.
  function automatic logic [N+1:0] ref_result(input logic [N-1:0] a, b, input logic cin);
    logic [N:0] full;
    logic       ovf;
    full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    ovf  = (a[N-1] == b[N-1]) && (full[N-1] != a[N-1]);
    return {full[N-1:0], full[N], ovf};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Offer one operand pair; the expected record enters the scoreboard only when the transfer happens.
  task automatic drive(input logic [N-1:0] a, b, input logic cin, input logic [N+1:0] exp);
    int w;
    w = 0;
    i_gg    = prefix_gg(a, b, cin);
    i_p     = {a ^ b, 1'($urandom_range(0, 1))};
    i_valid = 1'b1;
    @(negedge clk);
    while (!o_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!o_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: o_ready stuck at 0 for a=0x%0h b=0x%0h", a, b);
      i_valid = 1'b0;
      return;
    end
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_gg    = 'x;
    i_p     = 'x;
  endtask

  // Monitor: compare every popped result against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && o_valid && i_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_output: got sum=0x%0h with nothing expected", o_sum);
      end else begin
        logic [N+1:0] e;
        e = exp_q.pop_front();
        if ({o_sum, o_cout, o_ovf} !== e) begin
          errors++;
          $display("FAIL result: got sum=0x%0h cout=%0b ovf=%0b, expected sum=0x%0h cout=%0b ovf=%0b",
                   o_sum, o_cout, o_ovf, e[N+1:2], e[1], e[0]);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      i_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    logic [N-1:0] a, b;
    logic         cin;
    int           w;

    #1;
    check("reset_valid", 32'(o_valid), 32'd0);
    check("reset_sum", 32'(o_sum), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_ready", 32'(o_ready), 32'd1);

    // Single push: 1-cycle latency, 0x0F + 0x01 = 0x10.
    i_ready = 1'b1;
    drive(8'h0F, 8'h01, 1'b0, {8'h10, 1'b0, 1'b0});
    check("latency_valid", 32'(o_valid), 32'd1);
    check("latency_sum", 32'(o_sum), 32'h10);
    @(posedge clk);
    #1;

    // Carry-out, overflow, and both at once.
    drive(8'hFF, 8'h01, 1'b0, {8'h00, 1'b1, 1'b0});
    drive(8'h7F, 8'h01, 1'b0, {8'h80, 1'b0, 1'b1});
    drive(8'h80, 8'h80, 1'b0, {8'h00, 1'b1, 1'b1});
    drive(8'hFF, 8'hFF, 1'b1, {8'hFF, 1'b1, 1'b0});
    repeat (3) @(posedge clk);
    #1;
    check("idle_empty", 32'(o_valid), 32'd0);

    // Backpressure: two entries fill the buffer, the third waits upstream.
    i_ready = 1'b0;
    drive(8'h00, 8'h01, 1'b0, {8'h01, 1'b0, 1'b0});
    check("bp_ready_after_1", 32'(o_ready), 32'd1);
    drive(8'h00, 8'h02, 1'b0, {8'h02, 1'b0, 1'b0});
    check("bp_ready_after_2", 32'(o_ready), 32'd0);
    fork
      drive(8'h00, 8'h03, 1'b0, {8'h03, 1'b0, 1'b0});
      begin
        repeat (3) @(negedge clk);
        check("bp_full_ready", 32'(o_ready), 32'd0);
        check("bp_held_upstream", 32'(exp_q.size()), 32'd2);
        check("bp_head_sum", 32'(o_sum), 32'h01);
        @(posedge clk);
        #1;
        i_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Streaming push and pop together: occupancy stays at one, one result per cycle.
    for (int k = 0; k < 10; k++) begin
      drive(8'(k), 8'h01, 1'b0, {8'(k + 1), 1'b0, 1'b0});
      check("stream_valid", 32'(o_valid), 32'd1);
      check("stream_ready", 32'(o_ready), 32'd1);
      check("stream_head", 32'(o_sum), 32'(k + 1));
    end
    @(posedge clk);
    #1;
    check("stream_empty", 32'(o_valid), 32'd0);

    // Reset with two entries buffered discards them.
    i_ready = 1'b0;
    drive(8'h11, 8'h22, 1'b0, {8'h33, 1'b0, 1'b0});
    drive(8'h40, 8'h01, 1'b0, {8'h41, 1'b0, 1'b0});
    check("pre_reset_full", 32'(o_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_reset_valid", 32'(o_valid), 32'd0);
    check("mid_reset_sum", 32'(o_sum), 32'd0);
    check("mid_reset_cout_ovf", 32'({o_cout, o_ovf}), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_ready", 32'(o_ready), 32'd1);
    check("post_reset_valid", 32'(o_valid), 32'd0);
    i_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Random traffic against the arithmetic reference.
    rnd_ready = 1'b1;
    for (int t = 0; t < 10000; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      a   = N'($urandom);
      b   = N'($urandom);
      cin = 1'($urandom_range(0, 1));
      drive(a, b, cin, ref_result(a, b, cin));
    end
    rnd_ready = 1'b0;
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    #1;
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
